// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the parametrised UART receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with first-word fall-through; head reads as zero when empty.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, oversampling FSM, parity/framing check,
// receive FIFO and sticky overrun flag.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | line idle, waiting for a low level on rx_s
//  ST_START  | qualifying start bit, checked again at half a bit time
//  ST_DATA   | sampling DATA_BITS data bits at bit centre, LSB first
//  ST_PARITY | sampling the parity bit (only when PARITY != none)
//  ST_STOP   | sampling STOP_BITS stop bits; last one pushes the frame
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_en,
    input  logic                 rx,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] MID       = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST      = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == PARITY_ODD);

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;
    logic                 frame_start;
    logic                 sample_data;
    logic                 sample_par;
    logic                 sample_stop;
    logic                 push;
    logic                 push_ferr;
    logic                 par_bad;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS+1:0] fifo_head;

    // Two-flop synchroniser for the asynchronous serial line, reset to idle-high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; the FSM only moves on baud ticks.
    always_comb begin
        state_nxt = state;
        if (baud_en) begin
            case (state)
                ST_IDLE:   if (!rx_s) state_nxt = ST_START;
                ST_START:  if (cnt == MID) state_nxt = rx_s ? ST_IDLE : ST_DATA;
                ST_DATA:   if (cnt == LAST && idx == DATA_LAST)
                               state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                ST_PARITY: if (cnt == LAST) state_nxt = ST_STOP;
                ST_STOP:   if (cnt == LAST && idx == STOP_LAST) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: busy flag and per-tick sampling/push strobes.
    always_comb begin
        busy        = (state != ST_IDLE);
        frame_start = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        if (baud_en) begin
            frame_start = (state == ST_IDLE) && !rx_s;
            sample_data = (state == ST_DATA)   && (cnt == LAST);
            sample_par  = (state == ST_PARITY) && (cnt == LAST);
            sample_stop = (state == ST_STOP)   && (cnt == LAST);
        end
        push = sample_stop && (idx == STOP_LAST);
    end

    // Tick counter re-phases to bit centre when the start bit is confirmed at MID.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (baud_en) begin
            if (state == ST_IDLE || (state == ST_START && cnt == MID) || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    // Bit index (shared by data and stop bits), shift register and error flags.
    assign par_bad   = ((^shreg) ^ rx_s) != ODD_PAR;
    assign push_ferr = ferr | ~rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            if (frame_start) begin
                idx  <= '0;
                perr <= 1'b0;
                ferr <= 1'b0;
            end
            if (sample_data) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                idx   <= (idx == DATA_LAST) ? '0 : idx + IW'(1);
            end
            if (sample_par) perr <= par_bad;
            if (sample_stop) begin
                ferr <= push_ferr;
                idx  <= (idx == STOP_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // Sticky overrun: a dropped frame sets it, and setting wins over err_clr.
    always_ff @(posedge clk) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (push && fifo_full && !(rd_en && !fifo_empty))
            overrun <= 1'b1;
        else if (err_clr)
            overrun <= 1'b0;
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({perr, push_ferr, shreg}),
        .pop   (rd_en),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ready      = ~fifo_empty;
    assign parity_err = fifo_head[DATA_BITS+1];
    assign frame_err  = fifo_head[DATA_BITS];
    assign data_out   = fifo_head[DATA_BITS-1:0];

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations (8N1, 8E1, 7O2) share one
// clock and baud tick; expected frames are queued at send time and a monitor pops and
// compares whenever a receiver presents a FIFO entry.
module tb_uart_rx_param;

    localparam int OS    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [8:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_en;
    logic [2:0] rx;
    logic [2:0] rd_en;
    logic [2:0] err_clr;
    wire  [2:0] ready, busy, overrun, perr, ferr;
    wire  [7:0] d0, d1;
    wire  [6:0] d2;

    exp_t q0[$], q1[$], q2[$];
    logic [2:0] auto_rd;
    logic [2:0] exp_ovr;
    int n_cmp = 0;
    int n_bad = 0;
    int bdiv  = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) u0 (
        .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .rx(rx[0]), .rd_en(rd_en[0]), .err_clr(err_clr[0]),
        .data_out(d0), .parity_err(perr[0]), .frame_err(ferr[0]), .ready(ready[0]),
        .overrun(overrun[0]), .busy(busy[0]));

    uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) u1 (
        .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .rx(rx[1]), .rd_en(rd_en[1]), .err_clr(err_clr[1]),
        .data_out(d1), .parity_err(perr[1]), .frame_err(ferr[1]), .ready(ready[1]),
        .overrun(overrun[1]), .busy(busy[1]));

    uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) u2 (
        .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .rx(rx[2]), .rd_en(rd_en[2]), .err_clr(err_clr[2]),
        .data_out(d2), .parity_err(perr[2]), .frame_err(ferr[2]), .ready(ready[2]),
        .overrun(overrun[2]), .busy(busy[2]));

    function automatic int nb(int i);
        return (i == 2) ? 7 : 8;
    endfunction

    function automatic int par(int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int ns(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic logic [31:0] dout_of(int i);
        case (i)
            0:       return {24'd0, d0};
            1:       return {24'd0, d1};
            default: return {25'd0, d2};
        endcase
    endfunction

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int i, output exp_t e);
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[u%0d]: got %0h expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Baud tick: one clock high out of every three.
    initial begin
        baud_en = 1'b0;
        forever begin
            @(negedge clk);
            bdiv    = (bdiv == 2) ? 0 : bdiv + 1;
            baud_en = (bdiv == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        while (!baud_en) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int i, input logic v);
        rx[i] = v;
        repeat (OS) tick();
    endtask

    // Reference model: expected entry from the frame's own bits, FIFO occupancy from the queue.
    task automatic send_frame(input int i, input logic [8:0] v, input bit bad_par, input logic [1:0] stops);
        int         n;
        logic [8:0] m;
        logic       p;
        exp_t       e;
        n      = nb(i);
        m      = v & ((9'h1 << n) - 9'h1);
        p      = ^m;
        if (par(i) == 1) p = ~p;
        e.data = m;
        e.perr = (par(i) != 0) && bad_par;
        e.ferr = (stops[0] == 1'b0) || (ns(i) == 2 && stops[1] == 1'b0);
        if (!auto_rd[i] && qsize(i) >= DEPTH) exp_ovr[i] = 1'b1;
        else                                  qpush(i, e);
        drive_bit(i, 1'b0);
        for (int k = 0; k < n; k++) drive_bit(i, m[k]);
        if (par(i) != 0) drive_bit(i, p ^ bad_par);
        for (int s = 0; s < ns(i); s++) drive_bit(i, stops[s]);
        rx[i] = 1'b1;
        if (stops[ns(i)-1] == 1'b0) drive_bit(i, 1'b1);
    endtask

    task automatic drain(input int i);
        int t;
        t = 0;
        while (qsize(i) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", i, qsize(i), 0);
        repeat (2) @(negedge clk);
        chk("ready_after_drain", i, ready[i], 0);
    endtask

    task automatic chk_all_zero(input string tag, input int i);
        chk({tag, "_ready"}, i, ready[i], 0);
        chk({tag, "_busy"}, i, busy[i], 0);
        chk({tag, "_overrun"}, i, overrun[i], 0);
        chk({tag, "_data"}, i, dout_of(i), 0);
        chk({tag, "_perr"}, i, perr[i], 0);
        chk({tag, "_ferr"}, i, ferr[i], 0);
    endtask

    // Monitor: compare and pop the head whenever an auto-read receiver has data.
    initial begin
        exp_t e;
        rd_en = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst_n && auto_rd[i] && ready[i]) begin
                    if (qsize(i) == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_entry[u%0d]: got data %0h expected no entry", i, dout_of(i));
                    end else begin
                        qpop(i, e);
                        chk("data_out", i, dout_of(i), {23'd0, e.data});
                        chk("parity_err", i, perr[i], e.perr);
                        chk("frame_err", i, ferr[i], e.ferr);
                    end
                    rd_en[i] = 1'b1;
                end else begin
                    rd_en[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        rx      = 3'b111;
        err_clr = '0;
        auto_rd = 3'b111;
        exp_ovr = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_all_zero("reset", i);
        rst_n = 1'b1;
        repeat (40) tick();

        // Directed frames.
        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        drain(0);
        send_frame(1, 9'h003, 1'b1, 2'b11);
        send_frame(2, 9'h041, 1'b0, 2'b11);
        drain(1);
        drain(2);

        // False start: short low pulse must be rejected.
        rx[0] = 1'b0;
        repeat (6) tick();
        chk("glitch_busy_during", 0, busy[0], 1);
        rx[0] = 1'b1;
        repeat (24) tick();
        chk("glitch_busy_after", 0, busy[0], 0);
        chk("glitch_ready", 0, ready[0], 0);

        // Framing error then a clean frame.
        send_frame(0, 9'h055, 1'b0, 2'b00);
        send_frame(0, 9'h012, 1'b0, 2'b11);
        drain(0);

        // Random back-to-back frames on every configuration.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 3; i++) begin
                logic [1:0] st;
                st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                send_frame(i, 9'($urandom), ($urandom_range(0, 3) == 0), st);
            end
        end
        for (int i = 0; i < 3; i++) drain(i);

        // Overrun: five frames into a four-entry FIFO with no reads.
        auto_rd[0] = 1'b0;
        for (int v = 1; v <= 5; v++) send_frame(0, 9'(v), 1'b0, 2'b11);
        repeat (2) @(negedge clk);
        chk("overrun_set", 0, overrun[0], exp_ovr[0]);
        chk("full_ready", 0, ready[0], 1);
        auto_rd[0] = 1'b1;
        drain(0);
        chk("overrun_sticky", 0, overrun[0], exp_ovr[0]);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        exp_ovr[0] = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", 0, overrun[0], exp_ovr[0]);

        // Reset mid-DATA with an entry already held in the FIFO.
        auto_rd[0] = 1'b0;
        send_frame(0, 9'h077, 1'b0, 2'b11);
        repeat (2) @(negedge clk);
        chk("held_ready", 0, ready[0], 1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        repeat (5) tick();
        chk("mid_frame_busy", 0, busy[0], 1);
        @(negedge clk);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        exp_ovr = '0;
        chk_all_zero("midreset", 0);
        auto_rd[0] = 1'b1;
        repeat (40) tick();
        send_frame(0, 9'h03C, 1'b0, 2'b11);
        drain(0);

        for (int i = 0; i < 3; i++) begin
            chk("final_busy", i, busy[i], 0);
            chk("final_overrun", i, overrun[i], exp_ovr[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
